// File: rtl/facto_multiplier_if.sv
// Operand/result bundle between the factorial controller (master) and the
// shift-add multiplier (slave).
interface facto_multiplier_if #(
    parameter int WIDTH = 64
);
    // Handshake: op_start is taken only while the multiplier is idle. From
    // then on the operands are don't-care. op_done and result stay valid and
    // unchanged until the master pulses op_clear, which also drops a running
    // operation.
    logic               op_start;
    logic               op_clear;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic [2*WIDTH-1:0] result;
    logic               op_done;
    logic               busy;

    modport master (
        output op_start, op_clear, multiplicand, multiplier,
        input  result, op_done, busy
    );

    modport slave (
        input  op_start, op_clear, multiplicand, multiplier,
        output result, op_done, busy
    );
endinterface

// File: rtl/facto_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per clock, for the factorial controller.
// Optional macro FACTO_MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module facto_multiplier #(
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    facto_multiplier_if.slave      bus,
    output logic [1:0]             state_dbg
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] result_q;
    logic               busy_q;
    logic               done_q;
    logic               last_iter;

`ifdef FACTO_MUL_EARLY_TERM_EN
    // Once the bits still to be shifted in are all zero, no further adds can happen.
    assign last_iter = (count_q == CW'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
    assign last_iter = (count_q == CW'(WIDTH - 1));
`endif

    always_comb begin
        state_d = state_q;
        if (bus.op_clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.op_start) state_d = EXEC;
                EXEC:    if (last_iter) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == EXEC);
            done_q  <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else if (bus.op_clear) begin
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.op_start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, bus.multiplicand};
                        mplier_q <= bus.multiplier;
                        result_q <= '0;
                        count_q  <= '0;
                    end
                end
                EXEC: begin
                    // The 2*WIDTH-bit accumulator cannot overflow for WIDTH-bit operands.
                    if (mplier_q[0]) result_q <= result_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.result  = result_q;
    assign bus.op_done = done_q;
    assign bus.busy    = busy_q;
    assign state_dbg   = state_q;
endmodule
